// File: rtl/ariane_irq_conditioner.sv
// ariane_irq_conditioner
// Conditions raw peripheral interrupt lines before they reach the PLIC/timer wrapper.
// Each source goes through a synchroniser, a deglitch filter and then either a level
// output or an edge-to-pulse stretcher. All sources are independent and every output
// is registered.
module ariane_irq_conditioner #(
  parameter int unsigned        NUM_IRQ        = 26,
  parameter int unsigned        SYNC_STAGES    = 2,
  parameter int unsigned        FILTER_CYCLES  = 4,
  parameter int unsigned        STRETCH_CYCLES = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK      = '0
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [NUM_IRQ-1:0] irq_raw_i,
  output logic [NUM_IRQ-1:0] irq_o,
  output logic               uart_irq_o,
  output logic               spi_irq_o,
  output logic               eth_irq_o,
  output logic [NUM_IRQ-4:0] irq_ext_o,
  output logic [NUM_IRQ-1:0] edge_lost_o
);

  // A bypassed filter still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned      CNT_W        = (FILTER_CYCLES == 0) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'((FILTER_CYCLES == 0) ? 0 : FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [7:0]       STRETCH_LOAD = 8'(STRETCH_CYCLES);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_s;

  logic [NUM_IRQ-1:0] filt_q;
  logic [NUM_IRQ-1:0] filt_d;
  logic [CNT_W-1:0]   cnt_q [NUM_IRQ];
  logic [CNT_W-1:0]   cnt_d [NUM_IRQ];

  logic [NUM_IRQ-1:0] filt_prev_q;
  logic [NUM_IRQ-1:0] filt_prev_d;
  logic [NUM_IRQ-1:0] rise;
  logic [7:0]         stretch_q [NUM_IRQ];
  logic [7:0]         stretch_d [NUM_IRQ];

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] lost_q;
  logic [NUM_IRQ-1:0] lost_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 samples the asynchronous inputs, each later stage copies the previous one.
  always_comb begin
    sync_d[0] = irq_raw_i;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Deglitch filter: the filtered value only follows the synchronised input after it has
  // disagreed for FILTER_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      cnt_d[i] = '0;
      if (FILTER_CYCLES == 0) begin
        filt_d[i] = sync_s[i];
      end else if (sync_s[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Output stage: level sources register the filtered value; edge sources reload a stretch
  // counter on each filtered rising edge and flag a retrigger that lands inside a live pulse.
  always_comb begin
    filt_prev_d = filt_q;
    rise        = filt_q & ~filt_prev_q;
    irq_d       = '0;
    lost_d      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      stretch_d[i] = '0;
      if (EDGE_MASK[i]) begin
        if (rise[i]) begin
          stretch_d[i] = STRETCH_LOAD;
        end else if (stretch_q[i] != 8'd0) begin
          stretch_d[i] = stretch_q[i] - 8'd1;
        end
        irq_d[i]  = (stretch_d[i] != 8'd0);
        lost_d[i] = lost_q[i] | (rise[i] & (stretch_q[i] != 8'd0));
      end else begin
        irq_d[i]  = filt_q[i];
        lost_d[i] = 1'b0;
      end
    end
  end

  // Synchroniser flops.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  // Filter state and stable-cycle counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NUM_IRQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge detector history, stretch counters and the registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      filt_prev_q <= '0;
      irq_q       <= '0;
      lost_q      <= '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        stretch_q[i] <= '0;
      end
    end else begin
      filt_prev_q <= filt_prev_d;
      irq_q       <= irq_d;
      lost_q      <= lost_d;
      for (int i = 0; i < NUM_IRQ; i++) begin
        stretch_q[i] <= stretch_d[i];
      end
    end
  end

  assign irq_o       = irq_q;
  assign uart_irq_o  = irq_q[0];
  assign spi_irq_o   = irq_q[1];
  assign eth_irq_o   = irq_q[2];
  assign irq_ext_o   = irq_q[NUM_IRQ-1:3];
  assign edge_lost_o = lost_q;

endmodule

// File: tb/tb_ariane_irq_conditioner.sv
// Testbench for ariane_irq_conditioner. Three instances share the raw inputs and reset:
// a default-filter instance with eth in edge mode, a mixed-mask instance, and a
// filter-bypassed instance with eth in edge mode. A behavioural model tracks all three.
module tb_ariane_irq_conditioner;

  localparam int NIRQ    = 26;
  localparam int STRETCH = 8;
  localparam int NOEDGE  = 1000;

  logic            aclk;
  logic            areset;
  logic [NIRQ-1:0] irq_raw;

  logic [NIRQ-1:0] lvl_irq, mix_irq, fast_irq;
  logic [NIRQ-1:0] lvl_lost, mix_lost, fast_lost;
  logic            lvl_uart, lvl_spi, lvl_eth;
  logic            mix_uart, mix_spi, mix_eth;
  logic            fast_uart, fast_spi, fast_eth;
  logic [22:0]     lvl_ext, mix_ext, fast_ext;

  int vectors;
  int miscompares;

  // Model state, indexed by instance: 0 = lvl, 1 = mix, 2 = fast.
  logic [NIRQ-1:0] rawh [8];
  logic [NIRQ-1:0] m_f [3];
  logic [NIRQ-1:0] m_fp [3];
  logic [NIRQ-1:0] m_irq [3];
  logic [NIRQ-1:0] m_lost [3];
  int              since [3][NIRQ];

  ariane_irq_conditioner #(.FILTER_CYCLES(4), .EDGE_MASK(26'h0000004)) u_lvl (
    .aclk(aclk), .areset(areset), .irq_raw_i(irq_raw), .irq_o(lvl_irq),
    .uart_irq_o(lvl_uart), .spi_irq_o(lvl_spi), .eth_irq_o(lvl_eth),
    .irq_ext_o(lvl_ext), .edge_lost_o(lvl_lost));

  ariane_irq_conditioner #(.FILTER_CYCLES(4), .EDGE_MASK(26'h2AAAAAA)) u_mix (
    .aclk(aclk), .areset(areset), .irq_raw_i(irq_raw), .irq_o(mix_irq),
    .uart_irq_o(mix_uart), .spi_irq_o(mix_spi), .eth_irq_o(mix_eth),
    .irq_ext_o(mix_ext), .edge_lost_o(mix_lost));

  ariane_irq_conditioner #(.FILTER_CYCLES(0), .EDGE_MASK(26'h0000004)) u_fast (
    .aclk(aclk), .areset(areset), .irq_raw_i(irq_raw), .irq_o(fast_irq),
    .uart_irq_o(fast_uart), .spi_irq_o(fast_spi), .eth_irq_o(fast_eth),
    .irq_ext_o(fast_ext), .edge_lost_o(fast_lost));

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int fcOf(input int j);
    return (j == 2) ? 0 : 4;
  endfunction

  function automatic logic [NIRQ-1:0] maskOf(input int j);
    return (j == 1) ? 26'h2AAAAAA : 26'h0000004;
  endfunction

  // Filtered value: flips once the last FILTER_CYCLES synchronised samples all disagree with it.
  // rawh[k] (before this edge's shift) holds the synchronised value from k edges ago.
  function automatic logic [NIRQ-1:0] nextF(input int j);
    logic [NIRQ-1:0] nf;
    logic            all;
    nf = m_f[j];
    for (int i = 0; i < NIRQ; i++) begin
      if (fcOf(j) == 0) begin
        nf[i] = rawh[1][i];
      end else begin
        all = 1'b1;
        for (int k = 1; k <= fcOf(j); k++) begin
          if (rawh[k][i] == m_f[j][i]) all = 1'b0;
        end
        if (all) nf[i] = ~m_f[j][i];
      end
    end
    return nf;
  endfunction

  // Output: level sources echo the filtered value one cycle later; edge sources are high
  // while fewer than STRETCH cycles have passed since the most recent filtered rise.
  function automatic logic [NIRQ-1:0] nextIrq(input int j);
    logic [NIRQ-1:0] r;
    logic [NIRQ-1:0] o;
    r = m_f[j] & ~m_fp[j];
    o = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (maskOf(j)[i]) o[i] = r[i] ? 1'b1 : (since[j][i] + 1 < STRETCH);
      else              o[i] = m_f[j][i];
    end
    return o;
  endfunction

  // Reference model, advanced on every clock edge and cleared asynchronously by reset.
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < 8; k++) rawh[k] <= '0;
      for (int j = 0; j < 3; j++) begin
        m_f[j]    <= '0;
        m_fp[j]   <= '0;
        m_irq[j]  <= '0;
        m_lost[j] <= '0;
        for (int i = 0; i < NIRQ; i++) since[j][i] <= NOEDGE;
      end
    end else begin
      for (int k = 1; k < 8; k++) rawh[k] <= rawh[k-1];
      rawh[0] <= irq_raw;
      for (int j = 0; j < 3; j++) begin
        m_f[j]    <= nextF(j);
        m_fp[j]   <= m_f[j];
        m_irq[j]  <= nextIrq(j);
        m_lost[j] <= m_lost[j] | (m_f[j] & ~m_fp[j] & maskOf(j) & m_irq[j]);
        for (int i = 0; i < NIRQ; i++) begin
          if (maskOf(j)[i] && m_f[j][i] && !m_fp[j][i]) since[j][i] <= 0;
          else if (since[j][i] < NOEDGE)                 since[j][i] <= since[j][i] + 1;
        end
      end
    end
  end

  function automatic logic [NIRQ-1:0] obsIrq(input int j);
    case (j)
      0:       return lvl_irq;
      1:       return mix_irq;
      default: return fast_irq;
    endcase
  endfunction

  function automatic logic [NIRQ-1:0] obsLost(input int j);
    case (j)
      0:       return lvl_lost;
      1:       return mix_lost;
      default: return fast_lost;
    endcase
  endfunction

  function automatic logic [NIRQ-1:0] obsPorts(input int j);
    case (j)
      0:       return {lvl_ext, lvl_eth, lvl_spi, lvl_uart};
      1:       return {mix_ext, mix_eth, mix_spi, mix_uart};
      default: return {fast_ext, fast_eth, fast_spi, fast_uart};
    endcase
  endfunction

  function automatic string instName(input int j);
    case (j)
      0:       return "lvl";
      1:       return "mix";
      default: return "fast";
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [NIRQ-1:0] obs, input logic [NIRQ-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every instance against the model.
  task automatic checkAll();
    for (int j = 0; j < 3; j++) begin
      checkOutput({"irq_o_", instName(j)}, obsIrq(j), m_irq[j]);
      checkOutput({"ports_", instName(j)}, obsPorts(j), m_irq[j]);
      checkOutput({"lost_", instName(j)}, obsLost(j), m_lost[j]);
    end
  endtask

  task automatic applyStimulus(input logic [NIRQ-1:0] v);
    irq_raw = v;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(negedge aclk);
      checkAll();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    areset      = 1'b1;
    irq_raw     = '1;

    // T1: outputs held at zero during reset, uart level rises exactly 7 edges after release.
    $display("[TB] T1 reset");
    waitEdges(3);
    checkOutput("t1_rst_irq_lvl", lvl_irq, '0);
    checkOutput("t1_rst_irq_mix", mix_irq, '0);
    checkOutput("t1_rst_lost_lvl", lvl_lost, '0);
    areset = 1'b0;
    waitEdges(6);
    checkOutput("t1_uart_e6", {25'd0, lvl_uart}, 26'd0);
    waitEdges(1);
    checkOutput("t1_uart_e7", {25'd0, lvl_uart}, 26'd1);
    waitEdges(20);
    applyStimulus('0);
    waitEdges(20);

    // T2: 3-cycle glitch on idx3 is swallowed, a long pulse passes with 7-edge latency each way.
    $display("[TB] T2 glitch");
    applyStimulus(26'h8);
    waitEdges(3);
    applyStimulus('0);
    for (int e = 0; e < 15; e++) begin
      waitEdges(1);
      checkOutput("t2_glitch", {25'd0, lvl_ext[0]}, 26'd0);
    end
    applyStimulus(26'h8);
    waitEdges(6);
    checkOutput("t2_rise_e6", {25'd0, lvl_ext[0]}, 26'd0);
    waitEdges(1);
    checkOutput("t2_rise_e7", {25'd0, lvl_ext[0]}, 26'd1);
    waitEdges(5);
    applyStimulus('0);
    waitEdges(6);
    checkOutput("t2_fall_e6", {25'd0, lvl_ext[0]}, 26'd1);
    waitEdges(1);
    checkOutput("t2_fall_e7", {25'd0, lvl_ext[0]}, 26'd0);
    waitEdges(10);

    // T3: eth edge source held high produces a single 8-cycle pulse and no lost flag.
    $display("[TB] T3 edge pulse");
    applyStimulus(26'h4);
    waitEdges(6);
    checkOutput("t3_pre", {25'd0, lvl_eth}, 26'd0);
    for (int e = 0; e < STRETCH; e++) begin
      waitEdges(1);
      checkOutput("t3_high", {25'd0, lvl_eth}, 26'd1);
    end
    for (int e = 0; e < 36; e++) begin
      waitEdges(1);
      checkOutput("t3_after", {25'd0, lvl_eth}, 26'd0);
    end
    checkOutput("t3_lost", {25'd0, lvl_lost[2]}, 26'd0);
    applyStimulus('0);
    waitEdges(20);

    // T4: filter bypassed, second rise 5 cycles after the first extends the pulse to 13 cycles.
    $display("[TB] T4 retrigger");
    applyStimulus(26'h4);
    waitEdges(2);
    applyStimulus('0);
    waitEdges(1);
    checkOutput("t4_pre", {25'd0, fast_eth}, 26'd0);
    for (int e = 4; e <= 16; e++) begin
      waitEdges(1);
      checkOutput("t4_high", {25'd0, fast_eth}, 26'd1);
      if (e == 5) applyStimulus(26'h4);
    end
    waitEdges(1);
    checkOutput("t4_end", {25'd0, fast_eth}, 26'd0);
    checkOutput("t4_lost", {25'd0, fast_lost[2]}, 26'd1);
    applyStimulus('0);
    waitEdges(20);
    checkOutput("t4_lost_sticky", {25'd0, fast_lost[2]}, 26'd1);

    // T5: reset asserted three cycles into a pulse clears outputs at once; no pulse afterwards.
    $display("[TB] T5 mid-pulse reset");
    applyStimulus(26'h4);
    waitEdges(9);
    checkOutput("t5_in_pulse", {25'd0, lvl_eth}, 26'd1);
    #1 areset = 1'b1;
    #1;
    checkOutput("t5_async_irq", lvl_irq, '0);
    checkOutput("t5_async_lost", fast_lost, '0);
    checkAll();
    waitEdges(2);
    applyStimulus('0);
    areset = 1'b0;
    for (int e = 0; e < 30; e++) begin
      waitEdges(1);
      checkOutput("t5_no_pulse", {25'd0, lvl_eth}, 26'd0);
    end

    // T6: all inputs toggle together on the mixed-mask instance.
    $display("[TB] T6 simultaneous");
    applyStimulus('1);
    waitEdges(6);
    checkOutput("t6_e6", mix_irq, '0);
    waitEdges(1);
    checkOutput("t6_e7", mix_irq, 26'h3FFFFFF);
    waitEdges(7);
    checkOutput("t6_e14", mix_irq, 26'h3FFFFFF);
    waitEdges(1);
    checkOutput("t6_e15", mix_irq, 26'h1555555);
    waitEdges(20);
    applyStimulus('0);
    waitEdges(6);
    checkOutput("t6_fall_e6", mix_irq, 26'h1555555);
    waitEdges(1);
    checkOutput("t6_fall_e7", mix_irq, '0);
    checkOutput("t6_lost", mix_lost, '0);
    waitEdges(20);

    // Random phase: random bit flips held for random lengths, with one asynchronous reset.
    $display("[TB] random phase");
    for (int it = 0; it < 250; it++) begin
      applyStimulus(irq_raw ^ ($urandom() & $urandom() & 32'h03FF_FFFF));
      waitEdges($urandom_range(1, 7));
      if (it == 120) begin
        #3 areset = 1'b1;
        #1 checkAll();
        @(negedge aclk);
        checkAll();
        areset = 1'b0;
      end
    end
    applyStimulus('0);
    waitEdges(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
